// File: rtl/trng_pkg.sv
// trng_pkg: shared types and constants for the TRNG sampler.
// Holds the sampler FSM state encoding and the oscillator warm-up length.
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    COLLECT,
    FULL
  } state_t;

  localparam int WARMUP_CYCLES = 16;

endpackage

// File: rtl/trng_von_neumann.sv
// trng_von_neumann: pairwise von Neumann debiaser.
// Emits the first bit of an unequal pair on the pair's second tick.
module trng_von_neumann (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  input  logic din,
  output logic out_valid,
  output logic out_bit
);

  logic have_first;
  logic first_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      have_first <= 1'b0;
      first_bit  <= 1'b0;
    end else if (clear) begin
      have_first <= 1'b0;
      first_bit  <= 1'b0;
    end else if (tick) begin
      if (have_first) begin
        have_first <= 1'b0;
      end else begin
        have_first <= 1'b1;
        first_bit  <= din;
      end
    end
  end

  // 0/1 yields 0 and 1/0 yields 1, i.e. the stored bit
  assign out_valid = tick && !clear && have_first
                   && (first_bit != din);
  assign out_bit   = first_bit;

endmodule

// File: rtl/trng_sampler.sv
// trng_sampler: ring-oscillator sampler, debiaser and word packer.
// Define TRNG_HEALTH_EN to add the sticky repetition-count health test.
module trng_sampler
  import trng_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int DIV_W     = 8,
  parameter int REP_LIMIT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  sample_div,
  input  logic              ro_in,
  output logic              ro_enable,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              health_fail
);

  localparam int CNT_W  = $clog2(WORD_W);
  localparam int WARM_W = $clog2(WARMUP_CYCLES);

  state_t state_q;
  state_t state_d;

  logic [1:0]        sync_q;
  logic              s;
  logic [WARM_W-1:0] warm_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] word;

  logic tick;
  logic vn_clear;
  logic vn_valid;
  logic vn_bit;
  logic word_done;
  logic can_load;
  logic xfer;
  logic fail_now;

  assign s         = sync_q[1];
  assign ro_enable = (state_q != IDLE);
  assign xfer      = rnd_valid & rnd_ready;
  assign can_load  = !rnd_valid | rnd_ready;
  assign tick      = (state_q == COLLECT) && enable
                   && (div_cnt == sample_div);
  assign vn_clear  = !enable || (state_q == IDLE)
                   || (state_q == WARMUP);
  assign word_done = vn_valid
                   && (bit_cnt == CNT_W'(WORD_W - 1));
  assign word      = {shreg[WORD_W-2:0], vn_bit};

  trng_von_neumann u_vn (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (vn_clear),
    .tick      (tick),
    .din       (s),
    .out_valid (vn_valid),
    .out_bit   (vn_bit)
  );

`ifdef TRNG_HEALTH_EN
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_next;
  logic             last_s;
  logic             fail_q;

  always_comb begin
    rep_next = REP_W'(1);
    if (rep_cnt != '0 && s == last_s) begin
      rep_next = rep_cnt + 1'b1;
    end
  end

  assign fail_now    = tick && (rep_next == REP_W'(REP_LIMIT));
  assign health_fail = fail_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_cnt <= '0;
      last_s  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      if (fail_now) begin
        fail_q <= 1'b1;
      end
      if (tick) begin
        rep_cnt <= rep_next;
        last_s  <= s;
      end else if (!enable || state_q == IDLE) begin
        rep_cnt <= '0;
      end
    end
  end
`else
  assign fail_now    = 1'b0;
  assign health_fail = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable && !health_fail) state_d = WARMUP;
      end
      WARMUP: begin
        if (!enable) state_d = IDLE;
        else if (warm_cnt == WARM_W'(WARMUP_CYCLES - 1))
          state_d = COLLECT;
      end
      COLLECT: begin
        if (!enable) state_d = IDLE;
        else if (word_done && !can_load) state_d = FULL;
      end
      FULL: begin
        if (!enable) state_d = IDLE;
        else if (xfer) state_d = COLLECT;
      end
      default: state_d = IDLE;
    endcase
    if (fail_now) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      warm_cnt  <= '0;
      div_cnt   <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], ro_in};
      warm_cnt <= (state_q == WARMUP) ? warm_cnt + 1'b1 : '0;

      // >= also reloads when sample_div shrinks below the count
      if (state_q == COLLECT && enable) begin
        div_cnt <= (div_cnt >= sample_div) ? '0
                 : div_cnt + 1'b1;
      end else if (state_q != FULL || !enable) begin
        div_cnt <= '0;
      end

      if (xfer) rnd_valid <= 1'b0;

      // in FULL the pending word waits in shreg
      if (state_q == FULL) begin
        if (xfer && enable) begin
          rnd_data  <= shreg;
          rnd_valid <= 1'b1;
          shreg     <= '0;
        end
      end else if (vn_valid) begin
        shreg   <= word;
        bit_cnt <= bit_cnt + 1'b1;
        if (word_done) begin
          bit_cnt <= '0;
          if (can_load) begin
            rnd_data  <= word;
            rnd_valid <= 1'b1;
            shreg     <= '0;
          end
        end
      end

      if (vn_clear) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end

      if (fail_now) begin
        rnd_valid <= 1'b0;
        shreg     <= '0;
        bit_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_trng_sampler.sv
// tb_trng_sampler: directed bench for trng_sampler at WORD_W=8.
// Health scenario only runs when TRNG_HEALTH_EN is defined.
module tb_trng_sampler;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] sample_div;
  logic       ro_in;
  logic       ro_enable;
  logic [7:0] rnd_data;
  logic       rnd_valid;
  logic       rnd_ready;
  logic       health_fail;

  int checks;
  int errors;

  trng_sampler #(
    .WORD_W    (8),
    .DIV_W     (8),
    .REP_LIMIT (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sample_div  (sample_div),
    .ro_in       (ro_in),
    .ro_enable   (ro_enable),
    .rnd_data    (rnd_data),
    .rnd_valid   (rnd_valid),
    .rnd_ready   (rnd_ready),
    .health_fail (health_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // pair pattern 01,10,11,00
  function automatic logic pat(input int m);
    case (m % 8)
      1, 2, 4, 5: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  // ro_in driven before edge n after enable; sample k uses n=15+k
  function automatic logic vc(input int n);
    int m;
    if (n < 15) return 1'b0;
    m = n - 15;
    if (m < 32) return pat(m);
    if (m < 48) return (m % 2 == 0);
    return 1'b1;
  endfunction

  // sample_div=1: sample k uses n=16+2k, pairs encode 8'hA5
  function automatic logic vd(input int n);
    int k;
    logic [7:0] w;
    logic b;
    w = 8'hA5;
    if (n < 16) return 1'b0;
    k = (n - 16) / 2;
    if (k >= 16) return 1'b1;
    b = w[7 - k / 2];
    return (k % 2 == 0) ? b : !b;
  endfunction

  task automatic start_run();
    rst_n     = 1'b0;
    enable    = 1'b0;
    rnd_ready = 1'b0;
    ro_in     = 1'b1;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    enable     = 1'b1;
    ro_in      = 1'b1;
    rnd_ready  = 1'b1;
    sample_div = 8'd0;
    step();
    step();
    checks++;
    if ({ro_enable, rnd_valid, health_fail} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 000",
               {ro_enable, rnd_valid, health_fail});
    end
    checks++;
    if (rnd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %h exp 00", rnd_data);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (ro_enable !== 1'b1) begin
      errors++;
      $display("FAIL reset_roen got %b exp 1", ro_enable);
    end
    enable = 1'b0;
    step();
    checks++;
    if (ro_enable !== 1'b0) begin
      errors++;
      $display("FAIL warm_abort got %b exp 0", ro_enable);
    end
  endtask

  task automatic test_correction();
    start_run();
    sample_div = 8'd0;
    enable     = 1'b1;
    for (int n = 0; n <= 44; n++) begin
      ro_in = vc(n);
      step();
      if (n == 43) begin
        checks++;
        if (rnd_valid !== 1'b0) begin
          errors++;
          $display("FAIL corr_early got %b exp 0", rnd_valid);
        end
      end
    end
    checks++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'h55) begin
      errors++;
      $display("FAIL corr_word got %b/%h exp 1/55",
               rnd_valid, rnd_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 45; n <= 64; n++) begin
      ro_in = vc(n);
      step();
    end
    for (int j = 0; j < 6; j++) begin
      ro_in = j[0];
      step();
    end
    checks++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'h55) begin
      errors++;
      $display("FAIL bp_hold got %b/%h exp 1/55",
               rnd_valid, rnd_data);
    end
    ro_in     = 1'b1;
    rnd_ready = 1'b1;
    step();
    rnd_ready = 1'b0;
    checks++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'hFF) begin
      errors++;
      $display("FAIL bp_second got %b/%h exp 1/ff",
               rnd_valid, rnd_data);
    end
    step();
    checks++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'hFF) begin
      errors++;
      $display("FAIL bp_stable got %b/%h exp 1/ff",
               rnd_valid, rnd_data);
    end
    rnd_ready = 1'b1;
    step();
    rnd_ready = 1'b0;
    checks++;
    if (rnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got %b exp 0", rnd_valid);
    end
  endtask

  task automatic test_enable_drop();
    start_run();
    sample_div = 8'd0;
    enable     = 1'b1;
    for (int n = 0; n <= 34; n++) begin
      ro_in = vc(n);
      step();
    end
    enable = 1'b0;
    ro_in  = 1'b0;
    step();
    checks++;
    if (ro_enable !== 1'b0 || rnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_roen got %b/%b exp 0/0",
               ro_enable, rnd_valid);
    end
    enable = 1'b1;
    for (int n = 0; n <= 44; n++) begin
      ro_in = vc(n);
      step();
      if (n == 43) begin
        checks++;
        if (rnd_valid !== 1'b0) begin
          errors++;
          $display("FAIL drop_early got %b exp 0", rnd_valid);
        end
      end
    end
    checks++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'h55) begin
      errors++;
      $display("FAIL drop_word got %b/%h exp 1/55",
               rnd_valid, rnd_data);
    end
  endtask

  task automatic test_divider();
    int seen;
    start_run();
    sample_div = 8'd1;
    enable     = 1'b1;
    for (int n = 0; n <= 48; n++) begin
      ro_in = vd(n);
      step();
      if (n == 47) begin
        checks++;
        if (rnd_valid !== 1'b0) begin
          errors++;
          $display("FAIL div1_early got %b exp 0", rnd_valid);
        end
      end
    end
    checks++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'hA5) begin
      errors++;
      $display("FAIL div1_word got %b/%h exp 1/a5",
               rnd_valid, rnd_data);
    end
    rnd_ready  = 1'b1;
    sample_div = 8'd3;
    ro_in      = 1'b1;
    step();
    seen = 0;
    for (int j = 0; j < 80; j++) begin
      step();
      if (rnd_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL div3_const got %0d words exp 0", seen);
    end
    rnd_ready = 1'b0;
  endtask

  task automatic test_health();
    start_run();
    sample_div = 8'd0;
    enable     = 1'b1;
    ro_in      = 1'b1;
    for (int n = 0; n <= 48; n++) begin
      step();
      if (n == 47) begin
        checks++;
        if (health_fail !== 1'b0) begin
          errors++;
          $display("FAIL hf_early got %b exp 0", health_fail);
        end
      end
    end
`ifdef TRNG_HEALTH_EN
    checks++;
    if ({health_fail, ro_enable, rnd_valid} !== 3'b100) begin
      errors++;
      $display("FAIL hf_trip got %b exp 100",
               {health_fail, ro_enable, rnd_valid});
    end
    enable = 1'b0;
    step();
    enable = 1'b1;
    for (int j = 0; j < 4; j++) step();
    checks++;
    if ({health_fail, ro_enable} !== 2'b10) begin
      errors++;
      $display("FAIL hf_sticky got %b exp 10",
               {health_fail, ro_enable});
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (health_fail !== 1'b0) begin
      errors++;
      $display("FAIL hf_clear got %b exp 0", health_fail);
    end
`else
    checks++;
    if ({health_fail, ro_enable} !== 2'b01) begin
      errors++;
      $display("FAIL hf_off got %b exp 01",
               {health_fail, ro_enable});
    end
`endif
    enable = 1'b0;
    step();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    enable     = 1'b0;
    sample_div = 8'd0;
    ro_in      = 1'b0;
    rnd_ready  = 1'b0;
    test_reset();
    test_correction();
    test_back_to_back();
    test_enable_drop();
    test_divider();
    test_health();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
